ipm2l_hsstlp_tx_rate_req_ctrl_v1_4: RTL and testbench

//  Upstream driver of the TX lane reset FSM's rate-change inputs. Accepts a PCIe-rate request (Gen1/Gen2) from the
//  MAC/LTSSM side and maps it to a TX clock divider. Sequences i_txckdiv / i_tx_rate_chng into the TX lane FSM, then

---
 rtl/ipm2l_hsstlp_tx_rate_req_ctrl_v1_4_pkg.sv | 38 +++
 rtl/ipm2l_hsstlp_rst_tmr_v1_4.sv | 26 ++
 rtl/ipm2l_hsstlp_tx_rate_req_ctrl_v1_4.sv | 156 +++++++++++++++
 tb/tb_ipm2l_hsstlp_tx_rate_req_ctrl_v1_4.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ipm2l_hsstlp_tx_rate_req_ctrl_v1_4_pkg.sv
// Shared definitions for the TX rate-request controller: rate codes, FSM states,
// timer width and the rate-to-divider mapping.
package ipm2l_hsstlp_tx_rate_req_ctrl_v1_4_pkg;

  localparam int TMR_W = 12;

  localparam logic [1:0] RATE_GEN1 = 2'd0;
  localparam logic [1:0] RATE_GEN2 = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READY,
    ST_SETUP,
    ST_PULSE,
    ST_WAIT_START,
    ST_WAIT_DONE,
    ST_ACK
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] ckdiv;
  } rate_map_t;

  function automatic rate_map_t map_rate(input logic [1:0] rate,
                                         input logic [2:0] gen1_ckdiv,
                                         input logic [2:0] gen2_ckdiv);
    rate_map_t rm;
    rm = '{valid: 1'b0, ckdiv: '0};
    case (rate)
      RATE_GEN1: rm = '{valid: 1'b1, ckdiv: gen1_ckdiv};
      RATE_GEN2: rm = '{valid: 1'b1, ckdiv: gen2_ckdiv};
      default:   rm = '{valid: 1'b0, ckdiv: '0};
    endcase
    return rm;
  endfunction

endpackage

// File: rtl/ipm2l_hsstlp_rst_tmr_v1_4.sv
// Load/enable up-counter with a terminal-count flag against a caller-supplied value.
module ipm2l_hsstlp_rst_tmr_v1_4
  import ipm2l_hsstlp_tx_rate_req_ctrl_v1_4_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [TMR_W-1:0] tc_val,
  output logic             tc
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= '0;
    else if (en && cnt != '1)
      cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/ipm2l_hsstlp_tx_rate_req_ctrl_v1_4.sv
// Maps a PCIe rate request to a TX clock divider, strobes it into the TX lane
// reset FSM, waits for the lane to re-settle and returns a one-cycle ack.
module ipm2l_hsstlp_tx_rate_req_ctrl_v1_4
  import ipm2l_hsstlp_tx_rate_req_ctrl_v1_4_pkg::*;
#(
  parameter int         FREE_CLOCK_FREQ = 100,
  parameter logic [2:0] P_LX_TX_CKDIV   = 3'd0,
  parameter logic [2:0] P_GEN1_CKDIV    = 3'd1,
  parameter logic [2:0] P_GEN2_CKDIV    = 3'd0,
  parameter int         SETUP_CYC       = 4,
  parameter int         PULSE_CYC       = 4,
  parameter int         TIMEOUT_CYC     = 20 * FREE_CLOCK_FREQ
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rate_req,
  input  logic [1:0] i_rate,
  input  logic       i_txlane_done,
  input  logic       i_txckdiv_done,
  output logic       o_tx_rate_chng,
  output logic [2:0] o_txckdiv,
  output logic       o_busy,
  output logic       o_rate_ack,
  output logic       o_rate_err,
  output logic [2:0] o_cur_ckdiv
);

  localparam logic [TMR_W-1:0] SETUP_TC   = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] PULSE_TC   = TMR_W'(PULSE_CYC - 1);
  // Timeout fires one cycle early: the ack itself is registered in ST_ACK, so the
  // pulse lands exactly TIMEOUT_CYC cycles after the strobe falls.
  localparam logic [TMR_W-1:0] TIMEOUT_TC = TMR_W'(TIMEOUT_CYC - 2);

  state_t           state;
  logic             err_q;
  logic             timeout_q;
  rate_map_t        rm;
  logic             tmr_load;
  logic             tmr_tc;
  logic [TMR_W-1:0] tmr_tc_val;

  always_comb begin
    rm = map_rate(i_rate, P_GEN1_CKDIV, P_GEN2_CKDIV);
  end

  always_comb begin
    tmr_tc_val = TIMEOUT_TC;
    tmr_load   = 1'b0;
    case (state)
      ST_READY: tmr_load = 1'b1;
      ST_SETUP: begin tmr_tc_val = SETUP_TC; tmr_load = tmr_tc; end
      ST_PULSE: begin tmr_tc_val = PULSE_TC; tmr_load = tmr_tc; end
      default:  ;
    endcase
  end

  ipm2l_hsstlp_rst_tmr_v1_4 u_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .en     (1'b1),
    .tc_val (tmr_tc_val),
    .tc     (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      o_tx_rate_chng <= 1'b0;
      o_txckdiv      <= P_LX_TX_CKDIV;
      o_cur_ckdiv    <= P_LX_TX_CKDIV;
      o_busy         <= 1'b1;
      o_rate_ack     <= 1'b0;
      o_rate_err     <= 1'b0;
      err_q          <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      o_rate_ack <= 1'b0;
      o_rate_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_txlane_done) begin
            state  <= ST_READY;
            o_busy <= 1'b0;
          end
        end
        ST_READY: begin
          // Level check: READY is only ever entered with the lane done, so a low
          // level here is the lane re-reset and outranks a request.
          if (!i_txlane_done) begin
            o_cur_ckdiv <= P_LX_TX_CKDIV;
            state       <= ST_IDLE;
            o_busy      <= 1'b1;
          end else if (i_rate_req) begin
            o_busy    <= 1'b1;
            timeout_q <= 1'b0;
            if (!rm.valid) begin
              err_q <= 1'b1;
              state <= ST_ACK;
            end else if (rm.ckdiv == o_cur_ckdiv) begin
              err_q <= 1'b0;
              state <= ST_ACK;
            end else begin
              o_txckdiv <= rm.ckdiv;
              state     <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          if (tmr_tc) begin
            o_tx_rate_chng <= 1'b1;
            state          <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (tmr_tc) begin
            o_tx_rate_chng <= 1'b0;
            state          <= ST_WAIT_START;
          end
        end
        ST_WAIT_START: begin
          if (!i_txlane_done) begin
            state <= ST_WAIT_DONE;
          end else if (tmr_tc) begin
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
            state     <= ST_ACK;
          end
        end
        ST_WAIT_DONE: begin
          if (i_txlane_done && i_txckdiv_done) begin
            o_cur_ckdiv <= o_txckdiv;
            err_q       <= 1'b0;
            state       <= ST_ACK;
          end else if (tmr_tc) begin
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
            state     <= ST_ACK;
          end
        end
        ST_ACK: begin
          o_rate_ack <= 1'b1;
          o_rate_err <= err_q;
          if (timeout_q) begin
            state <= ST_IDLE;
          end else begin
            state  <= ST_READY;
            o_busy <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ipm2l_hsstlp_tx_rate_req_ctrl_v1_4.sv
// Directed bench for the TX rate-request controller against a small TX lane FSM model.
module tb_ipm2l_hsstlp_tx_rate_req_ctrl_v1_4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [1:0] rate = 2'd0;
  logic       lane_done = 1'b0;
  logic       lane_ckdiv_done = 1'b0;
  logic       chng;
  logic [2:0] txckdiv;
  logic       busy;
  logic       ack;
  logic       err;
  logic [2:0] cur;

  always #5 clk = ~clk;

  ipm2l_hsstlp_tx_rate_req_ctrl_v1_4 #(
    .FREE_CLOCK_FREQ (100),
    .P_LX_TX_CKDIV   (3'd0),
    .P_GEN1_CKDIV    (3'd1),
    .P_GEN2_CKDIV    (3'd0),
    .SETUP_CYC       (4),
    .PULSE_CYC       (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_rate_req     (req),
    .i_rate         (rate),
    .i_txlane_done  (lane_done),
    .i_txckdiv_done (lane_ckdiv_done),
    .o_tx_rate_chng (chng),
    .o_txckdiv      (txckdiv),
    .o_busy         (busy),
    .o_rate_ack     (ack),
    .o_rate_err     (err),
    .o_cur_ckdiv    (cur)
  );

  // Lane model: 2-FF edge detect on the strobe, divider captured a cycle earlier,
  // done drops for a while then returns together with ckdiv_done.
  logic       lane_up = 1'b0;
  logic       stuck = 1'b0;
  logic       c1 = 1'b0, c2 = 1'b0;
  logic [2:0] div_q = 3'd0;
  logic [2:0] p_tx_rate = 3'd0;
  int         lane_cnt = 0;

  always @(posedge clk) begin
    c1    <= chng;
    c2    <= c1;
    div_q <= txckdiv;
    if (!lane_up) begin
      lane_done <= 1'b0;
      lane_cnt  <= 0;
    end else if (!stuck && c1 && !c2) begin
      p_tx_rate       <= div_q;
      lane_done       <= 1'b0;
      lane_ckdiv_done <= 1'b0;
      lane_cnt        <= 8;
    end else if (lane_cnt > 0) begin
      lane_cnt <= lane_cnt - 1;
      if (lane_cnt == 1) begin
        lane_done       <= 1'b1;
        lane_ckdiv_done <= 1'b1;
      end
    end else begin
      lane_done <= 1'b1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy == 1'b0) break;
    end
    check(tag, busy, 0);
  endtask

  int rise_k, fall_k, hi_cnt, ack_k, ack_cnt, setup_ok;
  logic err_at, busy_at;

  // One-cycle request, then observe up to 3000 cycles; k=1 is the cycle after the request.
  task automatic run_req(input logic [1:0] r, input int extra_k, input logic [2:0] exp_div);
    rise_k = 0; fall_k = 0; hi_cnt = 0; ack_k = 0; ack_cnt = 0; setup_ok = 0;
    err_at = 1'b0; busy_at = 1'b0;
    @(negedge clk);
    rate = r;
    req  = 1'b1;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      req = (k == extra_k);
      if (k <= 4 && chng == 1'b0 && txckdiv == exp_div) setup_ok++;
      if (chng) begin
        hi_cnt++;
        if (rise_k == 0) rise_k = k;
      end else if (rise_k != 0 && fall_k == 0) begin
        fall_k = k;
      end
      if (ack) begin
        ack_cnt++;
        if (ack_k == 0) begin
          ack_k   = k;
          err_at  = err;
          busy_at = busy;
        end
      end
      if (ack_k != 0 && k >= ack_k + 30) break;
    end
    req = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_chng", chng, 0);
    check("rst_txckdiv", txckdiv, 0);
    check("rst_cur", cur, 0);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);

    // 1: reset release, lane comes up
    rst_n   = 1'b1;
    lane_up = 1'b1;
    wait_ready("t1_ready");
    check("t1_cur", cur, 0);
    check("t1_chng", chng, 0);

    // 2: Gen1 change
    run_req(2'd0, 0, 3'd1);
    check("t2_setup_stable", setup_ok, 4);
    check("t2_chng_rise", rise_k, 5);
    check("t2_chng_len", hi_cnt, 4);
    check("t2_lane_rate", p_tx_rate, 1);
    check("t2_ack_cnt", ack_cnt, 1);
    check("t2_err", err_at, 0);
    check("t2_cur", cur, 1);
    check("t2_busy", busy, 0);

    // 3: same-rate request
    run_req(2'd0, 0, 3'd1);
    check("t3_ack_lat", ack_k, 2);
    check("t3_ack_cnt", ack_cnt, 1);
    check("t3_err", err_at, 0);
    check("t3_no_chng", hi_cnt, 0);

    // 4: invalid rate
    run_req(2'd2, 0, 3'd1);
    check("t4_ack_lat", ack_k, 2);
    check("t4_err", err_at, 1);
    check("t4_txckdiv", txckdiv, 1);
    check("t4_cur", cur, 1);
    check("t4_no_chng", hi_cnt, 0);

    // lane re-reset while READY restores the post-reset divider
    @(negedge clk);
    lane_up = 1'b0;
    repeat (3) @(negedge clk);
    check("rr_busy", busy, 1);
    check("rr_cur", cur, 0);
    lane_up = 1'b1;
    wait_ready("rr_ready");

    // 5: lane never responds -> timeout
    stuck = 1'b1;
    run_req(2'd0, 0, 3'd1);
    check("t5_chng_fall", fall_k, 9);
    check("t5_timeout_lat", ack_k - fall_k, 2000);
    check("t5_err", err_at, 1);
    check("t5_busy_idle", busy_at, 1);
    check("t5_cur", cur, 0);
    wait_ready("t5_ready");
    stuck = 1'b0;

    // 6b: request during WAIT_DONE is dropped
    run_req(2'd0, 12, 3'd1);
    check("t6_ack_cnt", ack_cnt, 1);
    check("t6_err", err_at, 0);
    check("t6_cur", cur, 1);

    // 6a: reset mid-PULSE
    @(negedge clk);
    rate = 2'd1;
    req  = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (chng) break;
      @(negedge clk);
    end
    check("t6_in_pulse", chng, 1);
    @(negedge clk);
    rst_n   = 1'b0;
    lane_up = 1'b0;
    @(negedge clk);
    check("t6_rst_chng", chng, 0);
    check("t6_rst_txckdiv", txckdiv, 0);
    check("t6_rst_cur", cur, 0);
    check("t6_rst_busy", busy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
